// File: rtl/add_serial_nbit_pkg.sv
// add_serial_nbit_pkg: FSM state encoding and counter width helper for the serial adder
package add_serial_nbit_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/add_1bit.sv
// add_1bit: single-bit full adder cell
module add_1bit (
  output logic S1,
  output logic Cout1,
  input  logic A1,
  input  logic B1,
  input  logic Cin
);
  assign S1    = A1 ^ B1 ^ Cin;
  assign Cout1 = (A1 & B1) | (Cin & (A1 ^ B1));
endmodule

// File: rtl/add_serial_nbit.sv
// add_serial_nbit: multi-cycle adder/subtractor processing BITS_PER_CYCLE bits per clock
module add_serial_nbit
  import add_serial_nbit_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = clog2(N);
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_a, r_b, r_acc;
  logic                    r_carry;
  logic [BITS_PER_CYCLE:0] w_c;
  logic [BITS_PER_CYCLE-1:0] w_s;
  logic [WIDTH-1:0]        w_acc_nxt;
  assign w_c[0]    = r_carry;
  assign busy      = r_state != ST_IDLE;
  // each slice enters at the MSB end so after N slices the result is aligned
  assign w_acc_nxt = WIDTH'({w_s, r_acc} >> BITS_PER_CYCLE);
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    add_1bit u_fa (.S1(w_s[i]), .Cout1(w_c[i+1]), .A1(r_a[i]), .B1(r_b[i]), .Cin(w_c[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub ? 1'b1 : cin;
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_a     <= r_a >> BITS_PER_CYCLE;
          r_b     <= r_b >> BITS_PER_CYCLE;
          r_carry <= w_c[BITS_PER_CYCLE];
          r_acc   <= w_acc_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            sum     <= w_acc_nxt;
            cout    <= w_c[BITS_PER_CYCLE];
            ovf     <= w_c[BITS_PER_CYCLE-1] ^ w_c[BITS_PER_CYCLE];
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
